// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB3 requester.
package apb_master_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned WAIT_CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_mst_state_e;

endpackage

// File: rtl/apb_master_if.sv
// Command, response and APB signal bundle between the requester and its environment.
interface apb_master_if
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_addr;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              rsp_timeout;

    logic [ADDR_W-1:0] paddr;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output paddr, psel, penable, pwrite, pwdata
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_wdata, rsp_ready, prdata, pready, pslverr,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  paddr, psel, penable, pwrite, pwdata
    );

endinterface

// File: rtl/apb_master_wdog.sv
// Saturating ACCESS wait counter with a programmable expiry compare.
module apb_master_wdog
    import apb_master_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  clear_i,
    input  logic                  inc_i,
    input  logic [WAIT_CNT_W-1:0] limit_i,
    output logic                  expired_o
);

    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts the low-pready cycles already seen, so the current cycle is cnt_q+1.
    assign expired_o = (limit_i != '0) && (cnt_q >= (limit_i - WAIT_CNT_W'(1)));

endmodule

// File: rtl/apb_master.sv
// APB3 requester: one outstanding transfer from a valid/ready command stream,
// with registered response channel and optional pready watchdog.
module apb_master
    import apb_master_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input logic          clk,
    input logic          resetn,
    apb_master_if.master bus
);

    localparam logic [WAIT_CNT_W-1:0] TimeoutLimit = WAIT_CNT_W'(TIMEOUT_CYCLES);

    apb_mst_state_e    state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic              pwrite_q, pwrite_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic wd_clear, wd_inc, wd_expired;

    apb_master_wdog u_wdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear_i  (wd_clear),
        .inc_i    (wd_inc),
        .limit_i  (TimeoutLimit),
        .expired_o(wd_expired)
    );

    always_comb begin
        state_d       = state_q;
        paddr_d       = paddr_q;
        pwrite_d      = pwrite_q;
        pwdata_d      = pwdata_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;
        wd_clear      = 1'b0;
        wd_inc        = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    paddr_d  = bus.cmd_addr;
                    pwrite_d = bus.cmd_write;
                    pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                    psel_d   = 1'b1;
                    wd_clear = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
            end
            ACCESS: begin
                // A late pready in the final watchdog cycle still completes normally.
                if (bus.pready || wd_expired) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = (bus.pready && !pwrite_q) ? bus.prdata : '0;
                    rsp_err_d     = bus.pready ? bus.pslverr : 1'b1;
                    rsp_timeout_d = !bus.pready;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    paddr_d       = '0;
                    pwrite_d      = 1'b0;
                    pwdata_d      = '0;
                    state_d       = RESP;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            paddr_q       <= '0;
            pwrite_q      <= 1'b0;
            pwdata_q      <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            paddr_q       <= paddr_d;
            pwrite_q      <= pwrite_d;
            pwdata_q      <= pwdata_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.cmd_ready   = (state_q == IDLE);
    assign bus.paddr       = paddr_q;
    assign bus.pwrite      = pwrite_q;
    assign bus.pwdata      = pwdata_q;
    assign bus.psel        = psel_q;
    assign bus.penable     = penable_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master with a response scoreboard and cycle-exact APB checks.
module tb_apb_master;

    localparam int unsigned TO = 5;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        timeout;
    } rsp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    rsp_t sb[$];

    apb_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    apb_master #(
        .ADDR_W        (32),
        .DATA_W        (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transfer: waits = pready-low ACCESS cycles, rdy_delay = rsp_ready-low RESP cycles.
    // hold keeps cmd_valid high (addr 0x44 read) during the response stall.
    task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] wd,
                        input int waits, input logic [31:0] rd, input logic se,
                        input int rdy_delay, input logic hold);
        rsp_t e;
        rsp_t got;
        logic to;
        int   n;
        to        = (waits >= int'(TO));
        n         = to ? int'(TO) : waits + 1;
        e.rdata   = (to || w) ? 32'h0 : rd;
        e.err     = to ? 1'b1 : se;
        e.timeout = to;
        sb.push_back(e);

        chk("cmd_ready_idle", bus.cmd_ready, 1);
        chk("psel_idle", bus.psel, 0);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_write = w;
        bus.cmd_wdata = wd;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ~a;
        bus.cmd_write = ~w;
        bus.cmd_wdata = ~wd;

        chk("psel_setup", bus.psel, 1);
        chk("penable_setup", bus.penable, 0);
        chk("paddr_setup", bus.paddr, a);
        chk("pwrite_setup", bus.pwrite, w);
        chk("pwdata_setup", bus.pwdata, w ? wd : 32'h0);
        chk("cmd_ready_setup", bus.cmd_ready, 0);
        tick();

        for (int k = 1; k <= n; k++) begin
            bus.pready  = (k > waits);
            bus.prdata  = bus.pready ? rd : ~rd;
            bus.pslverr = bus.pready ? se : ~se;
            chk("psel_access", bus.psel, 1);
            chk("penable_access", bus.penable, 1);
            chk("paddr_access", bus.paddr, a);
            chk("pwdata_access", bus.pwdata, w ? wd : 32'h0);
            chk("rsp_valid_access", bus.rsp_valid, 0);
            tick();
        end
        bus.pready  = 1'b0;
        bus.prdata  = 32'h0;
        bus.pslverr = 1'b0;
        chk("psel_resp", bus.psel, 0);
        chk("penable_resp", bus.penable, 0);

        for (int k = 0; k < rdy_delay; k++) begin
            if (hold) begin
                bus.cmd_valid = 1'b1;
                bus.cmd_addr  = 32'h44;
                bus.cmd_write = 1'b0;
                bus.cmd_wdata = 32'h0;
            end
            chk("rsp_valid_stall", bus.rsp_valid, 1);
            chk("rsp_rdata_stall", bus.rsp_rdata, sb[0].rdata);
            chk("rsp_err_stall", bus.rsp_err, sb[0].err);
            chk("rsp_timeout_stall", bus.rsp_timeout, sb[0].timeout);
            chk("cmd_ready_stall", bus.cmd_ready, 0);
            tick();
        end

        bus.rsp_ready = 1'b1;
        chk("rsp_valid", bus.rsp_valid, 1);
        chk("cmd_ready_resp", bus.cmd_ready, 0);
        if (sb.size() == 0) begin
            chk("sb_underflow", 32'(sb.size()), 1);
        end else begin
            got = sb.pop_front();
            chk("rsp_rdata", bus.rsp_rdata, got.rdata);
            chk("rsp_err", bus.rsp_err, got.err);
            chk("rsp_timeout", bus.rsp_timeout, got.timeout);
        end
        tick();
        bus.rsp_ready = 1'b0;
        chk("rsp_valid_done", bus.rsp_valid, 0);
        chk("psel_done", bus.psel, 0);
        chk("cmd_ready_done", bus.cmd_ready, 1);
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 32'h0;
        bus.cmd_write = 1'b0;
        bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0;
        bus.prdata    = 32'h0;
        bus.pready    = 1'b0;
        bus.pslverr   = 1'b0;

        repeat (3) tick();
        chk("rst_psel", bus.psel, 0);
        chk("rst_penable", bus.penable, 0);
        chk("rst_paddr", bus.paddr, 0);
        chk("rst_pwrite", bus.pwrite, 0);
        chk("rst_pwdata", bus.pwdata, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_timeout", bus.rsp_timeout, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        resetn = 1'b1;
        tick();

        xfer(32'h10, 1'b1, 32'hDEADBEEF, 0, 32'h12345678, 1'b0, 0, 1'b0);
        xfer(32'h20, 1'b0, 32'h0, 3, 32'hCAFE0001, 1'b0, 0, 1'b0);
        xfer(32'h30, 1'b0, 32'h0, 0, 32'hBAD0BAD0, 1'b1, 1, 1'b0);
        xfer(32'h40, 1'b0, 32'h0, 100, 32'h00000055, 1'b0, 0, 1'b0);
        xfer(32'h48, 1'b0, 32'h0, 4, 32'h600DF00D, 1'b0, 0, 1'b0);
        xfer(32'h50, 1'b1, 32'h11112222, 1, 32'h0, 1'b1, 4, 1'b1);
        // Command held valid through the stall above is accepted the cycle after handshake.
        xfer(32'h44, 1'b0, 32'h0, 0, 32'h0A0B0C0D, 1'b0, 0, 1'b0);

        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = 32'h60;
        bus.cmd_write = 1'b1;
        bus.cmd_wdata = 32'h77;
        tick();
        bus.cmd_valid = 1'b0;
        tick();
        chk("penable_pre_reset", bus.penable, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("psel_async_reset", bus.psel, 0);
        chk("penable_async_reset", bus.penable, 0);
        chk("rsp_valid_async_reset", bus.rsp_valid, 0);
        tick();
        resetn = 1'b1;
        tick();

        xfer(32'h70, 1'b1, 32'hA5A5A5A5, 0, 32'h0, 1'b0, 0, 1'b0);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_master.md
Name: apb_master

Overview:
Synthesizable APB3 requester that turns a valid/ready command stream into APB transfers and returns read data and status on a valid/ready response channel. It drives the same APB signal set that the slave driver BFM responds to. Its intended use is inside bus bridges and test harnesses that need a real RTL initiator. It handles one outstanding transfer at a time and has an optional watchdog for slaves that never assert pready.

Parameters:
ADDR_W, 32, width of paddr and cmd_addr.
DATA_W, 32, width of pwdata, prdata, cmd_wdata and rsp_rdata.
TIMEOUT_CYCLES, 0, maximum number of ACCESS cycles allowed with pready low. 0 disables the watchdog. Legal range is 0..65535.

Ports:
clk  in  1  clock; every register samples on the rising edge.
resetn  in  1  asynchronous active-low reset.
cmd_valid  in  1  command request.
cmd_ready  out  1  command accepted when high in the same cycle as cmd_valid.
cmd_addr  in  ADDR_W  transfer address.
cmd_write  in  1  1 = write, 0 = read.
cmd_wdata  in  DATA_W  write data.
rsp_valid  out  1  response available.
rsp_ready  in  1  response consumed when high in the same cycle as rsp_valid.
rsp_rdata  out  DATA_W  read data; 0 for writes and for timeouts.
rsp_err  out  1  pslverr was sampled high, or the transfer timed out.
rsp_timeout  out  1  the watchdog terminated the transfer.
paddr  out  ADDR_W  APB address.
psel  out  1  APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
pwdata  out  DATA_W  APB write data.
prdata  in  DATA_W  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB slave error.

Behaviour:
- Reset (resetn low, asynchronous):
  - state goes to IDLE.
  - psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err and rsp_timeout are all 0.
  - The wait counter is cleared.
- State machine: IDLE -> SETUP -> ACCESS -> RESP -> IDLE. All outputs come from registers, except cmd_ready, which is (state==IDLE).
- IDLE:
  - psel=0, penable=0, and the APB address/data/direction outputs are 0.
  - cmd_valid&&cmd_ready at an edge latches cmd_addr, cmd_write and cmd_wdata, and the state moves to SETUP.
- SETUP (exactly one cycle):
  - psel=1, penable=0.
  - paddr=latched address; pwrite=latched direction.
  - pwdata=latched wdata for a write, 0 for a read.
  - The state always moves to ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr, pwrite and pwdata are held stable.
  - At an edge with pready=1:
    - capture rsp_rdata (prdata for a read, 0 for a write), rsp_err=pslverr, rsp_timeout=0;
    - psel and penable go to 0;
    - the state moves to RESP.
  - At an edge with pready=0: the wait counter increments.
  - Timeout: if TIMEOUT_CYCLES!=0 and pready is still 0 at the edge ending the TIMEOUT_CYCLES-th ACCESS cycle:
    - psel and penable go to 0;
    - rsp_rdata=0, rsp_err=1, rsp_timeout=1;
    - the state moves to RESP.
  - pready=1 in that same final cycle wins: the transfer completes normally.
- RESP:
  - rsp_valid=1; the rsp_* outputs are held stable while rsp_valid&&!rsp_ready.
  - rsp_valid&&rsp_ready at an edge moves the state to IDLE and clears rsp_valid.
  - A new command is not accepted in the same cycle.
- Latency, zero wait states: command accepted at edge N -> SETUP in cycle N+1, ACCESS in N+2, rsp_valid high in N+3. Each pready-low cycle adds 1. The minimum command-to-command spacing is 4 cycles.
- Wait counter: 16 bits, cleared on entry to SETUP, saturating.
- cmd_* inputs are ignored outside IDLE. pslverr and prdata are sampled only at the completing ACCESS edge.
- Reset mid-transfer drops psel and penable immediately (asynchronously). Any pending response is discarded.

Decomposition:
- Package apb_master_pkg:
  - state enum apb_mst_state_e {IDLE, SETUP, ACCESS, RESP};
  - default width localparams;
  - WAIT_CNT_W=16.
- Optional sub-module: apb_master_wdog, holding the wait counter and timeout compare (inputs: clear, inc, limit; output: expired). All other logic stays in apb_master.

Test Plan:
- Write, zero wait states, addr 0x10, wdata 0xDEADBEEF -> SETUP in cycle N+1 with paddr=0x10, pwrite=1, pwdata=0xDEADBEEF, penable=0; ACCESS in N+2; rsp_valid in N+3 with rsp_err=0, rsp_rdata=0.
- Read, slave inserts 3 pready-low cycles, prdata=0xCAFE0001 -> penable high for 4 cycles with paddr stable; rsp_rdata=0xCAFE0001 and rsp_valid in N+6.
- Read with pslverr=1 at the completing edge -> rsp_err=1, rsp_timeout=0, rsp_rdata=prdata.
- TIMEOUT_CYCLES=5, pready never asserted -> psel drops after 5 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 in the 5th ACCESS cycle -> normal completion with rsp_timeout=0.
- rsp_ready held low for 4 cycles while cmd_valid is held high -> rsp_* stay stable, cmd_ready=0 throughout; the next SETUP starts 2 cycles after the rsp handshake edge.
- resetn driven low during ACCESS -> psel=0, penable=0 and rsp_valid=0 immediately; after reset is released, a fresh write completes normally.
